// File: rtl/gfx_pkg.sv
// Shared definitions for the G10k command scheduler: bus decode constant,
// command widths and the scheduler state encoding.
package gfx_pkg;

    localparam logic [1:0] GFX_DEVADDR = 2'd2;
    localparam int         GFX_CMD_W   = 24;
    localparam int         GFX_OP_W    = 8;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } gfx_state_e;

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO with asynchronously reset pointers.
// A push into a full FIFO is dropped even when a pop happens on the same edge.
module gfx_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [GFX_CMD_W-1:0]       din,
    input  logic                       pop,
    output logic [GFX_CMD_W-1:0]       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [GFX_CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever read out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/gfx_cmd_scheduler.sv
// G10k command scheduler: decodes bus words into immediate/deferred FIFOs and
// issues paced commands. Define GFX_SCHED_OVF_EN to build the sticky overflow flag.
module gfx_cmd_scheduler
    import gfx_pkg::*;
#(
    parameter logic [1:0] DEVADDR   = GFX_DEVADDR,
    parameter int         IMM_DEPTH = 8,
    parameter int         DEF_DEPTH = 16,
    parameter int         GAP       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in,
    input  logic                 vblank,
    output logic [GFX_CMD_W-1:0] cmd,
    output logic                 cmd_start,
    output logic                 busy,
    output logic                 batch_done,
    output logic                 ovf
);

    localparam int IAW = $clog2(IMM_DEPTH);
    localparam int DAW = $clog2(DEF_DEPTH);

    logic                 hit, imm_push, def_push, imm_pop, def_pop;
    logic [GFX_CMD_W-1:0] imm_dout, def_dout;
    logic                 imm_full, imm_empty, def_full, def_empty;
    logic [IAW:0]         imm_count_unused;
    logic [DAW:0]         def_count;
    logic [4:0]           in_bits_unused;
    logic                 frame_evt;

    gfx_state_e           state_q, state_d;
    logic [3:0]           gap_q, gap_d;
    logic [DAW:0]         batch_q, batch_d;
    logic                 frame_pend_q, frame_pend_d;
    logic                 vblank_in_q, vblank_in_d;
    logic                 vblank_q, vblank_d;
    logic [GFX_CMD_W-1:0] cmd_q, cmd_d;
    logic                 cmd_start_q, cmd_start_d;
    logic                 batch_done_q, batch_done_d;

    assign hit            = (in[31:30] == DEVADDR);
    assign imm_push       = hit && !in[29];
    assign def_push       = hit && in[29];
    assign in_bits_unused = in[28:24];

    gfx_cmd_fifo #(.DEPTH(IMM_DEPTH)) u_imm_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (imm_push),
        .din   (in[GFX_CMD_W-1:0]),
        .pop   (imm_pop),
        .dout  (imm_dout),
        .full  (imm_full),
        .empty (imm_empty),
        .count (imm_count_unused)
    );

    gfx_cmd_fifo #(.DEPTH(DEF_DEPTH)) u_def_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (def_push),
        .din   (in[GFX_CMD_W-1:0]),
        .pop   (def_pop),
        .dout  (def_dout),
        .full  (def_full),
        .empty (def_empty),
        .count (def_count)
    );

    // vblank is captured once, then compared with its previous sample.
    assign frame_evt = vblank_in_q && !vblank_q;

    always_comb begin
        state_d      = state_q;
        gap_d        = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
        batch_d      = batch_q;
        frame_pend_d = frame_pend_q;
        vblank_in_d  = vblank;
        vblank_d     = vblank_in_q;
        cmd_d        = '0;
        cmd_start_d  = 1'b0;
        batch_done_d = 1'b0;
        imm_pop      = 1'b0;
        def_pop      = 1'b0;
        case (state_q)
            RUN: begin
                if ((frame_evt || frame_pend_q) && !def_empty) begin
                    // Batch size is frozen here; later deferred pushes wait a frame.
                    state_d      = DRAIN;
                    batch_d      = def_count;
                    frame_pend_d = 1'b0;
                end else begin
                    frame_pend_d = 1'b0;
                    if (!imm_empty && gap_q == 4'd0) begin
                        imm_pop     = 1'b1;
                        cmd_d       = imm_dout;
                        cmd_start_d = 1'b1;
                        gap_d       = 4'(GAP);
                    end
                end
            end
            DRAIN: begin
                if (frame_evt) frame_pend_d = 1'b1;
                if (gap_q == 4'd0 && !def_empty) begin
                    def_pop     = 1'b1;
                    cmd_d       = def_dout;
                    cmd_start_d = 1'b1;
                    gap_d       = 4'(GAP);
                    batch_d     = batch_q - 1'b1;
                    if (batch_q == (DAW+1)'(1)) begin
                        batch_done_d = 1'b1;
                        state_d      = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            gap_q        <= '0;
            batch_q      <= '0;
            frame_pend_q <= 1'b0;
            vblank_in_q  <= 1'b0;
            vblank_q     <= 1'b0;
            cmd_q        <= '0;
            cmd_start_q  <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            batch_q      <= batch_d;
            frame_pend_q <= frame_pend_d;
            vblank_in_q  <= vblank_in_d;
            vblank_q     <= vblank_d;
            cmd_q        <= cmd_d;
            cmd_start_q  <= cmd_start_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_start  = cmd_start_q;
    assign batch_done = batch_done_q;
    assign busy       = !imm_empty || !def_empty || (state_q != RUN);

`ifdef GFX_SCHED_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q || (imm_push && imm_full) || (def_push && def_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Bench for gfx_cmd_scheduler: three instances (GAP 0, 2, 15) driven with
// directed words; a negedge monitor checks every issued command against a queue.
module tb_gfx_cmd_scheduler;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] cmd;
        logic        bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en;
    logic [31:0] cyc = '0;
    int          errors = 0;
    int          checks = 0;
    logic        ovf_exp;

    logic [31:0] in_a, in_b, in_c;
    logic        vb_a, vb_b, vb_c;
    logic [23:0] cmd_a, cmd_b, cmd_c;
    logic        st_a, st_b, st_c;
    logic        busy_a, busy_b, busy_c;
    logic        bd_a, bd_b, bd_c;
    logic        ovf_a, ovf_b, ovf_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gfx_cmd_scheduler #(.GAP(0)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .vblank(vb_a), .cmd(cmd_a),
        .cmd_start(st_a), .busy(busy_a), .batch_done(bd_a), .ovf(ovf_a)
    );
    gfx_cmd_scheduler #(.GAP(2)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .vblank(vb_b), .cmd(cmd_b),
        .cmd_start(st_b), .busy(busy_b), .batch_done(bd_b), .ovf(ovf_b)
    );
    gfx_cmd_scheduler #(.GAP(15)) dut_c (
        .clk(clk), .rst(rst), .in(in_c), .vblank(vb_c), .cmd(cmd_c),
        .cmd_start(st_c), .busy(busy_c), .batch_done(bd_c), .ovf(ovf_c)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_cmd(input int idx, input logic [31:0] c, input logic [23:0] cm, input logic bd);
        exp_t e;
        e.cyc = c;
        e.cmd = cm;
        e.bd  = bd;
        case (idx)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic check_port(input int idx, input logic st, input logic [23:0] c, input logic bd);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        checks++;
        if (st) begin
            case (idx)
                0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
                1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
                default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                errors++;
                $display("FAIL unexpected_issue dut%0d: got cmd %h bd %b at cyc %0d, expected no issue",
                         idx, c, bd, cyc);
            end else if (e.cyc != cyc || e.cmd != c || e.bd != bd) begin
                errors++;
                $display("FAIL issue dut%0d: got cyc %0d cmd %h bd %b, expected cyc %0d cmd %h bd %b",
                         idx, cyc, c, bd, e.cyc, e.cmd, e.bd);
            end
        end else if (c != 24'd0 || bd) begin
            errors++;
            $display("FAIL idle_outputs dut%0d: got cmd %h bd %b at cyc %0d, expected 0 0", idx, c, bd, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_port(0, st_a, cmd_a, bd_a);
            check_port(1, st_b, cmd_b, bd_b);
            check_port(2, st_c, cmd_c, bd_c);
        end
    end

    initial begin
        logic [31:0] c0;
        logic [31:0] v0;
`ifdef GFX_SCHED_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        in_a = '0; in_b = '0; in_c = '0;
        vb_a = 1'b0; vb_b = 1'b0; vb_c = 1'b0;
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cmd", {8'd0, cmd_a}, 32'd0);
        chk("reset_start", {31'd0, st_a}, 32'd0);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_done", {31'd0, bd_c}, 32'd0);
        chk("reset_ovf", {31'd0, ovf_c}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single immediate, a back-to-back second, then a foreign-device word.
        in_a = 32'h8001_0000; expect_cmd(0, cyc + 2, 24'h010000, 1'b0);
        @(negedge clk);
        in_a = 32'h9F12_3456; expect_cmd(0, cyc + 2, 24'h123456, 1'b0);
        @(negedge clk);
        in_a = 32'h4001_0000;
        @(negedge clk);
        in_a = '0;
        repeat (5) @(negedge clk);

        // Pacing with GAP=2: pulses 3 cycles apart.
        c0 = cyc;
        in_b = 32'h8011_1111; expect_cmd(1, c0 + 2, 24'h111111, 1'b0);
        @(negedge clk);
        in_b = 32'h8022_2222; expect_cmd(1, c0 + 5, 24'h222222, 1'b0);
        @(negedge clk);
        in_b = 32'h8033_3333; expect_cmd(1, c0 + 8, 24'h333333, 1'b0);
        @(negedge clk);
        in_b = '0;
        @(negedge clk);
        chk("pacing_busy_high", {31'd0, busy_b}, 32'd1);
        repeat (5) @(negedge clk);
        chk("pacing_busy_low", {31'd0, busy_b}, 32'd0);

        // Deferred batch held until vblank rises.
        in_a = 32'hA00A_0032;
        @(negedge clk);
        in_a = 32'hA00B_0032;
        @(negedge clk);
        in_a = '0;
        repeat (6) @(negedge clk);
        chk("deferred_busy", {31'd0, busy_a}, 32'd1);
        v0 = cyc;
        vb_a = 1'b1;
        expect_cmd(0, v0 + 3, 24'h0A0032, 1'b0);
        expect_cmd(0, v0 + 4, 24'h0B0032, 1'b1);
        repeat (8) @(negedge clk);
        vb_a = 1'b0;
        repeat (3) @(negedge clk);

        // Immediate pushed mid-drain waits; deferred pushed mid-drain waits a frame.
        in_a = 32'hA00C_0001;
        @(negedge clk);
        in_a = 32'hA00D_0002;
        @(negedge clk);
        in_a = '0;
        repeat (3) @(negedge clk);
        v0 = cyc;
        vb_a = 1'b1;
        expect_cmd(0, v0 + 3, 24'h0C0001, 1'b0);
        expect_cmd(0, v0 + 4, 24'h0D0002, 1'b1);
        repeat (2) @(negedge clk);
        in_a = 32'h800E_0001; expect_cmd(0, v0 + 5, 24'h0E0001, 1'b0);
        @(negedge clk);
        in_a = 32'hA00F_0003;
        @(negedge clk);
        in_a = '0;
        repeat (10) @(negedge clk);
        vb_a = 1'b0;
        repeat (3) @(negedge clk);
        v0 = cyc;
        vb_a = 1'b1;
        expect_cmd(0, v0 + 3, 24'h0F0003, 1'b1);
        repeat (6) @(negedge clk);
        vb_a = 1'b0;
        repeat (2) @(negedge clk);

        // Overflow with GAP=15: one command opens a gap, then 9 pushes; the 9th is dropped.
        c0 = cyc;
        in_c = 32'h8020_0000; expect_cmd(2, c0 + 2, 24'h200000, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) chk("ovf_before_drop", {31'd0, ovf_c}, 32'd0);
            in_c = 32'h8021_0000 + 32'(i);
            if (i < 8) expect_cmd(2, c0 + 18 + 32'(16 * i), 24'h210000 + 24'(i), 1'b0);
        end
        @(negedge clk);
        in_c = '0;
        chk("ovf_after_drop", {31'd0, ovf_c}, {31'd0, ovf_exp});
        repeat (140) @(negedge clk);
        chk("ovf_sticky", {31'd0, ovf_c}, {31'd0, ovf_exp});
        repeat (20) @(negedge clk);

        // Reset while the first of four deferred commands is on the output.
        for (int i = 1; i <= 4; i++) begin
            in_c = 32'hA030_0000 + 32'(i);
            @(negedge clk);
        end
        in_c = '0;
        repeat (2) @(negedge clk);
        v0 = cyc;
        vb_c = 1'b1;
        expect_cmd(2, v0 + 3, 24'h300001, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        vb_c = 1'b0;
        #1;
        chk("midrst_cmd", {8'd0, cmd_c}, 32'd0);
        chk("midrst_start", {31'd0, st_c}, 32'd0);
        chk("midrst_busy", {31'd0, busy_c}, 32'd0);
        chk("midrst_done", {31'd0, bd_c}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf_c}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vb_c = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_busy", {31'd0, busy_c}, 32'd0);
        vb_c = 1'b0;
        repeat (2) @(negedge clk);

        chk("pending_a", 32'(q_a.size()), 32'd0);
        chk("pending_b", 32'(q_b.size()), 32'd0);
        chk("pending_c", 32'(q_c.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
